fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 1, meaning load-use stall length in cycles (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have port ex_rd  input  5  destination register of the instruction in EX.
REQ-006 SHALL have port ex_mem_read  input  1  EX instruction is a load.
REQ-007 SHALL have port ex_branch_taken  input  1  taken branch or jump resolved in EX.
REQ-008 SHALL have port ex_branch_target  input  32  redirect address from EX.
REQ-009 SHALL have port mem_busy  input  1  data memory not ready; the pipeline must freeze.
REQ-010 SHALL have port halt_req  input  1  halting instruction (ecall/ebreak) is in ID.
REQ-011 SHALL have port PCWrite  output  1  PC increments by 4 at the next edge.
REQ-012 SHALL have port branch  output  1  PC loads branchPC at the next edge.
REQ-013 SHALL have port branchPC  output  32  redirect target.
REQ-014 SHALL have port ifid_write, ifid_flush, idex_bubble, freeze  output  1 each  pipeline register controls.
REQ-015 SHALL have port halted  output  1  core is halted.
REQ-016 SHALL have port stall_cnt, redirect_cnt  output  16 each  performance counters.

Function
REQ-017 SHALL implement FSM states RUN, LU_STALL, HALT, with a 4-bit down-counter lu_cnt.
REQ-018 SHALL detect load-use as ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
REQ-019 SHALL evaluate events in RUN with priority mem_busy > ex_branch_taken > load-use > halt_req > normal.
REQ-020 SHALL drive normal RUN as PCWrite=1, ifid_write=1, and all other controls 0.
REQ-021 SHALL, on mem_busy in any non-HALT state, drive freeze=1 with all other controls 0, and hold state and lu_cnt.
REQ-022 SHALL, on taken branch in RUN, drive PCWrite=0, branch=1, branchPC=ex_branch_target, ifid_flush=1, idex_bubble=1, ifid_write=1, and stay in RUN; PCWrite and branch are never both 1.
REQ-023 SHALL, on load-use in RUN, drive PCWrite=0, ifid_write=0, idex_bubble=1, with LOAD_LAT=1 staying in RUN, else entering LU_STALL with lu_cnt=LOAD_LAT-1.
REQ-024 SHALL, in LU_STALL without mem_busy, drive the REQ-023 outputs, decrement lu_cnt, and return to RUN at the edge where lu_cnt==1.
REQ-025 SHALL ignore ex_branch_taken, halt_req and new load-use in LU_STALL.
REQ-026 SHALL, on halt_req in RUN without higher-priority events, drive PCWrite=0, ifid_write=0, idex_bubble=1 and enter HALT.
REQ-027 SHALL drive outputs in HALT as halted=1, PCWrite=0, ifid_write=0, idex_bubble=1, and remain in HALT until rst, ignoring all inputs.
REQ-028 SHALL drive branchPC=0 whenever branch=0.
REQ-029 SHALL increment stall_cnt each cycle where PCWrite=0 and branch=0 outside HALT, saturating at 16'hFFFF.
REQ-030 SHALL increment redirect_cnt each cycle branch=1, saturating at 16'hFFFF.
REQ-031 SHALL decode outputs combinationally from state and inputs; state, lu_cnt and counters are registered.

Reset
REQ-032 SHALL, while rst=1, force state=RUN, lu_cnt=0, stall_cnt=0, redirect_cnt=0, and all outputs 0, including PCWrite.
REQ-033 SHALL treat rst asserted mid-stall or in HALT as immediately aborting; the first edge after rst deassertion behaves as normal RUN.

Verification
REQ-034 SHALL cover: reset release, no hazards for 10 cycles -> PCWrite=1 every cycle, stall_cnt=0.
REQ-035 SHALL cover: LOAD_LAT=3, ex_mem_read=1, ex_rd=5, id_rs2=5 -> exactly 3 cycles of PCWrite=0 and idex_bubble=1, stall_cnt=3; ex_rd=0 instead -> no stall.
REQ-036 SHALL cover: ex_branch_taken=1 with target 32'h40, same cycle as a load-use -> branch=1, branchPC=32'h40, PCWrite=0, ifid_flush=1, redirect_cnt=1.
REQ-037 SHALL cover: mem_busy high for 4 cycles during LU_STALL with lu_cnt=1 -> freeze=1 for 4 cycles, then 1 stall cycle, then RUN.
REQ-038 SHALL cover: halt_req=1 -> halted=1 next cycle and stays through branch/mem_busy stimulus; rst pulse -> PCWrite=1 after release.
REQ-039 SHALL cover: force stall_cnt to 16'hFFFE, 3 stall cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch/hazard controller: orders stalls, redirects, memory freeze and halt,
// and keeps saturating stall/redirect performance counters.
module fetch_ctrl #(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        mem_busy,
  input  logic        halt_req,
  output logic        PCWrite,
  output logic        branch,
  output logic [31:0] branchPC,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        freeze,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] lu_cnt, lu_cnt_nxt;
  logic       load_use;
  logic       stall_inc;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      lu_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  // Outputs are held low while rst is asserted.
  always_comb begin
    state_nxt   = state;
    lu_cnt_nxt  = lu_cnt;
    PCWrite     = 1'b0;
    branch      = 1'b0;
    branchPC    = 32'd0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            freeze = 1'b1;
          end else if (ex_branch_taken) begin
            branch      = 1'b1;
            branchPC    = ex_branch_target;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            ifid_write  = 1'b1;
          end else if (load_use) begin
            idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt  = LU_STALL;
              lu_cnt_nxt = 4'(LOAD_LAT - 1);
            end
          end else if (halt_req) begin
            idex_bubble = 1'b1;
            state_nxt   = HALT;
          end else begin
            PCWrite    = 1'b1;
            ifid_write = 1'b1;
          end
        end
        LU_STALL: begin
          if (mem_busy) begin
            freeze = 1'b1;
          end else begin
            idex_bubble = 1'b1;
            lu_cnt_nxt  = lu_cnt - 4'd1;
            if (lu_cnt <= 4'd1) begin
              state_nxt  = RUN;
              lu_cnt_nxt = 4'd0;
            end
          end
        end
        HALT: begin
          halted      = 1'b1;
          idex_bubble = 1'b1;
        end
        default: begin
          state_nxt  = RUN;
          lu_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  assign stall_inc = !rst && !PCWrite && !branch && (state != HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt    <= 16'd0;
      redirect_cnt <= 16'd0;
    end else begin
      if (stall_inc && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (branch && (redirect_cnt != 16'hFFFF))
        redirect_cnt <= redirect_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (LOAD_LAT=3): reset, load-use, branch,
// freeze during stall, halt/reset recovery and counter saturation.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read, ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        mem_busy, halt_req;
  logic        PCWrite, branch, ifid_write, ifid_flush;
  logic        idex_bubble, freeze, halted;
  logic [31:0] branchPC;
  logic [15:0] stall_cnt, redirect_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.LOAD_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .mem_busy(mem_busy), .halt_req(halt_req),
    .PCWrite(PCWrite), .branch(branch), .branchPC(branchPC),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .freeze(freeze), .halted(halted),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    ex_branch_target = 32'd0; mem_busy = 1'b0; halt_req = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    next();
    next();
    @(negedge clk);
    check("rst_pcwrite", 32'(PCWrite), 32'd0);
    check("rst_ifid_write", 32'(ifid_write), 32'd0);
    check("rst_bubble", 32'(idex_bubble), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_redir_cnt", 32'(redirect_cnt), 32'd0);
    next();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("run_pcwrite", 32'(PCWrite), 32'd1);
      check("run_ifid_write", 32'(ifid_write), 32'd1);
      next();
    end
    check("run_stall_cnt", 32'(stall_cnt), 32'd0);

    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lu_pcwrite", 32'(PCWrite), 32'd0);
      check("lu_bubble", 32'(idex_bubble), 32'd1);
      check("lu_ifid_write", 32'(ifid_write), 32'd0);
      next();
      idle();
    end
    @(negedge clk);
    check("lu_done_pcwrite", 32'(PCWrite), 32'd1);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd3);
    next();

    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    @(negedge clk);
    check("x0_pcwrite", 32'(PCWrite), 32'd1);
    check("x0_bubble", 32'(idex_bubble), 32'd0);
    next();
    idle();
    check("x0_stall_cnt", 32'(stall_cnt), 32'd3);

    ex_branch_taken = 1'b1; ex_branch_target = 32'h40;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    @(negedge clk);
    check("br_branch", 32'(branch), 32'd1);
    check("br_target", branchPC, 32'h40);
    check("br_pcwrite", 32'(PCWrite), 32'd0);
    check("br_flush", 32'(ifid_flush), 32'd1);
    check("br_bubble", 32'(idex_bubble), 32'd1);
    next();
    idle();
    @(negedge clk);
    check("br_redir_cnt", 32'(redirect_cnt), 32'd1);
    check("br_after_pcwrite", 32'(PCWrite), 32'd1);
    check("br_after_pc", branchPC, 32'd0);
    check("br_stall_cnt", 32'(stall_cnt), 32'd3);
    next();

    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
    @(negedge clk);
    check("fz_lu_pcwrite", 32'(PCWrite), 32'd0);
    next();
    idle();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h99;
    @(negedge clk);
    check("fz_lus_bubble", 32'(idex_bubble), 32'd1);
    check("fz_lus_nobranch", 32'(branch), 32'd0);
    next();
    idle();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fz_freeze", 32'(freeze), 32'd1);
      check("fz_bubble", 32'(idex_bubble), 32'd0);
      check("fz_pcwrite", 32'(PCWrite), 32'd0);
      next();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    check("fz_last_freeze", 32'(freeze), 32'd0);
    check("fz_last_bubble", 32'(idex_bubble), 32'd1);
    check("fz_last_pcwrite", 32'(PCWrite), 32'd0);
    next();
    @(negedge clk);
    check("fz_run_pcwrite", 32'(PCWrite), 32'd1);
    check("fz_stall_cnt", 32'(stall_cnt), 32'd10);
    next();

    halt_req = 1'b1;
    @(negedge clk);
    check("ht_req_halted", 32'(halted), 32'd0);
    check("ht_req_pcwrite", 32'(PCWrite), 32'd0);
    next();
    idle();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h80; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ht_halted", 32'(halted), 32'd1);
      check("ht_branch", 32'(branch), 32'd0);
      check("ht_freeze", 32'(freeze), 32'd0);
      check("ht_bubble", 32'(idex_bubble), 32'd1);
      check("ht_pcwrite", 32'(PCWrite), 32'd0);
      next();
    end
    check("ht_stall_cnt", 32'(stall_cnt), 32'd11);
    check("ht_redir_cnt", 32'(redirect_cnt), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("hr_halted", 32'(halted), 32'd0);
    check("hr_pcwrite", 32'(PCWrite), 32'd0);
    check("hr_stall_cnt", 32'(stall_cnt), 32'd0);
    next();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("hr_run_pcwrite", 32'(PCWrite), 32'd1);
    check("hr_run_halted", 32'(halted), 32'd0);
    next();

    mem_busy = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 32'(stall_cnt), 32'h0000FFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat_ffff", 32'(stall_cnt), 32'h0000FFFF);
    check("sat_freeze", 32'(freeze), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
